mul_issue_ctrl: RTL and testbench

//  Sequences the free-running, non-stallable 32x32 signed DSP multiplier for the RV32M
//  MUL/MULH/MULHSU/MULHU ops. The multiplier has 6 register stages.

---
 rtl/mul_issue_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mul_issue_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_ctrl.sv
// Issue sequencer for a free-running 6-stage signed DSP multiplier (RV32M MUL/MULH/MULHSU/MULHU).
// Optional perf counters are compiled in when MUL_PERF_CNT_EN is defined.
module mul_issue_ctrl #(
  parameter int unsigned MUL_LAT   = 6,
  parameter int unsigned OUT_DEPTH = 8,
  parameter int unsigned TAG_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  input  logic [63:0]      mul_res,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
`ifdef MUL_PERF_CNT_EN
  output logic [31:0]      perf_issued,
  output logic [31:0]      perf_stall,
`endif
  output logic             busy
);

  localparam int unsigned PtrW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(OUT_DEPTH + 1);

  localparam logic [1:0] OpMul    = 2'd0;
  localparam logic [1:0] OpMulhsu = 2'd2;
  localparam logic [1:0] OpMulhu  = 2'd3;

  logic             accept, push, pop;
  logic [31:0]      corr;
  logic [31:0]      tail_res;

  logic [MUL_LAT-1:0] pipe_vld_q;
  logic [1:0]         pipe_op_q   [MUL_LAT];
  logic [TAG_W-1:0]   pipe_tag_q  [MUL_LAT];
  logic [31:0]        pipe_corr_q [MUL_LAT];

  logic [31:0]      fifo_data_q [OUT_DEPTH];
  logic [TAG_W-1:0] fifo_tag_q  [OUT_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q, occ_q;
  logic [31:0]      hold_data_q;
  logic [TAG_W-1:0] hold_tag_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign mul_a = req_a;
  assign mul_b = req_b;

  // occ counts slots reserved at issue, so a tail write always finds room in the FIFO.
  assign req_ready = !flush && (occ_q < CntW'(OUT_DEPTH));
  assign accept    = req_valid && req_ready;
  assign res_valid = (cnt_q != '0);
  assign pop       = res_valid && res_ready && !flush;
  assign push      = pipe_vld_q[MUL_LAT-1] && !flush;
  assign busy      = (occ_q != '0);

  // Turns the signed high word into the unsigned/mixed-sign high word.
  always_comb begin
    corr = '0;
    case (req_op)
      OpMulhsu: corr = req_b[31] ? req_a : '0;
      OpMulhu:  corr = (req_a[31] ? req_b : '0) + (req_b[31] ? req_a : '0);
      default:  corr = '0;
    endcase
  end

  always_comb begin
    if (pipe_op_q[MUL_LAT-1] == OpMul) begin
      tail_res = mul_res[31:0];
    end else begin
      tail_res = mul_res[63:32] + pipe_corr_q[MUL_LAT-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q <= '0;
    end else if (flush) begin
      pipe_vld_q <= '0;
    end else begin
      pipe_vld_q[0] <= accept;
      for (int i = 1; i < MUL_LAT; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_op_q[0]   <= req_op;
    pipe_tag_q[0]  <= req_tag;
    pipe_corr_q[0] <= corr;
    for (int i = 1; i < MUL_LAT; i++) begin
      pipe_op_q[i]   <= pipe_op_q[i-1];
      pipe_tag_q[i]  <= pipe_tag_q[i-1];
      pipe_corr_q[i] <= pipe_corr_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      occ_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      unique case ({accept, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // On a full FIFO the written slot equals the head; the pop reads the old entry first.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= tail_res;
      fifo_tag_q[wr_ptr_q]  <= pipe_tag_q[MUL_LAT-1];
    end
  end

  assign res_data = res_valid ? fifo_data_q[rd_ptr_q] : hold_data_q;
  assign res_tag  = res_valid ? fifo_tag_q[rd_ptr_q]  : hold_tag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data_q <= '0;
      hold_tag_q  <= '0;
    end else begin
      hold_data_q <= res_data;
      hold_tag_q  <= res_tag;
    end
  end

`ifdef MUL_PERF_CNT_EN
  logic [31:0] perf_issued_q, perf_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (accept)                             perf_issued_q <= perf_issued_q + 1'b1;
      if (req_valid && !req_ready && !flush) perf_stall_q  <= perf_stall_q + 1'b1;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: DSP multiplier model plus an in-order reference queue of RV32M results.
module tb_mul_issue_ctrl;
  localparam int MUL_LAT   = 6;
  localparam int OUT_DEPTH = 8;
  localparam int TAG_W     = 5;
  localparam int LAT       = 7;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0, req_ready;
  logic [1:0]       req_op = '0;
  logic [31:0]      req_a = '0, req_b = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             flush = 1'b0;
  logic [31:0]      mul_a, mul_b;
  logic [63:0]      mul_res;
  logic             res_valid, res_ready = 1'b0;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic             busy;
`ifdef MUL_PERF_CNT_EN
  logic [31:0]      perf_issued, perf_stall;
`endif

  always #5 clk = ~clk;

  mul_issue_ctrl #(.MUL_LAT(MUL_LAT), .OUT_DEPTH(OUT_DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .flush(flush), .mul_a(mul_a),
    .mul_b(mul_b), .mul_res(mul_res), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag),
`ifdef MUL_PERF_CNT_EN
    .perf_issued(perf_issued), .perf_stall(perf_stall),
`endif
    .busy(busy)
  );

  // Free-running signed DSP: product of the operands seen at an edge appears MUL_LAT cycles later.
  logic [63:0] dsp_q [MUL_LAT];
  always @(posedge clk) begin
    dsp_q[0] <= {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
    for (int i = 1; i < MUL_LAT; i++) dsp_q[i] <= dsp_q[i-1];
  end
  assign mul_res = dsp_q[MUL_LAT-1];

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    int               cyc;
  } ent_t;

  ent_t             mq[$];
  int               tests = 0, fails = 0, cyc = 0;
  int unsigned      pf_iss = 0, pf_stall = 0;
  logic             e_ready, e_valid, e_busy;
  logic [31:0]      e_data = '0;
  logic [TAG_W-1:0] e_tag = '0;

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] sa, sb, za, zb, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    za = {32'b0, a};
    zb = {32'b0, b};
    case (op)
      2'd0, 2'd1: p = sa * sb;
      2'd2:       p = sa * zb;
      default:    p = za * zb;
    endcase
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 4))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  // One clock cycle: drive inputs, then derive expected outputs and advance the reference queue.
  task automatic tick(input logic v, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [TAG_W-1:0] tg, input logic rr,
                      input logic fl);
    ent_t e;
    @(posedge clk);
    cyc++;
    #1;
    req_valid = v; req_op = op; req_a = a; req_b = b; req_tag = tg; res_ready = rr; flush = fl;
    #1;
    e_ready = !fl && (mq.size() < OUT_DEPTH);
    e_busy  = (mq.size() != 0);
    e_valid = 1'b0;
    if (mq.size() != 0) e_valid = (cyc >= mq[0].cyc + LAT);
    if (e_valid) begin
      e_data = mq[0].data;
      e_tag  = mq[0].tag;
    end
    if (v && e_ready) pf_iss++;
    if (v && !e_ready && !fl) pf_stall++;
    if (fl) begin
      mq.delete();
    end else begin
      if (e_valid && rr) mq.delete(0);
      if (v && e_ready) begin
        e.tag = tg; e.data = ref_result(op, a, b); e.cyc = cyc;
        mq.push_back(e);
      end
    end
  endtask

  task automatic idle(input logic rr);
    tick(1'b0, 2'd0, 32'h0, 32'h0, '0, rr, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (mq.size() != 0 || busy); i++) idle(1'b1);
    idle(1'b1);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b0);
    tests += 5;
    if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", res_valid); end
    if (res_data !== 32'h0) begin fails++; $display("FAIL reset_data got=%h exp=0", res_data); end
    if (res_tag !== '0) begin fails++; $display("FAIL reset_tag got=%h exp=0", res_tag); end
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_latency();
    int c0, first;
    logic [31:0] d;
    logic [TAG_W-1:0] t;
    first = -1; d = '0; t = '0;
    tick(1'b1, 2'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 1'b1, 1'b0);
    c0 = cyc;
    for (int i = 0; i < 12; i++) begin
      idle(1'b1);
      if (res_valid && first < 0) begin first = cyc; d = res_data; t = res_tag; end
    end
    tests += 5;
    if (first != c0 + 7) begin fails++; $display("FAIL lat_cycle got=%0d exp=%0d", first - c0, 7); end
    if (d !== 32'hFFFF_FFEB) begin fails++; $display("FAIL lat_data got=%h exp=ffffffeb", d); end
    if (t !== 5'd3) begin fails++; $display("FAIL lat_tag got=%h exp=3", t); end
    if (res_valid !== 1'b0) begin fails++; $display("FAIL lat_after_pop got=%b exp=0", res_valid); end
    if (res_data !== 32'hFFFF_FFEB) begin
      fails++; $display("FAIL hold_data got=%h exp=ffffffeb", res_data);
    end
  endtask

  task automatic test_ops();
    logic [31:0] k [3];
    int n;
    k[0] = 32'hFFFF_FFFE; k[1] = 32'h4000_0000; k[2] = 32'hFFFF_FFFF;
    n = 0;
    tick(1'b1, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b1, 1'b0);
    tick(1'b1, 2'd1, 32'h8000_0000, 32'h8000_0000, 5'd2, 1'b1, 1'b0);
    tick(1'b1, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      idle(1'b1);
      if (res_valid && n < 3) begin
        tests += 2;
        if (res_data !== k[n]) begin fails++; $display("FAIL ops_data%0d got=%h exp=%h", n, res_data, k[n]); end
        if (res_tag !== TAG_W'(n + 1)) begin fails++; $display("FAIL ops_tag%0d got=%0d exp=%0d", n, res_tag, n + 1); end
        n++;
      end
    end
    tests++;
    if (n != 3) begin fails++; $display("FAIL ops_count got=%0d exp=3", n); end
  endtask

  task automatic test_back_pressure();
    int acc, got;
    acc = 0; got = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 2'($urandom), pick_operand(), pick_operand(), TAG_W'(i), 1'b0, 1'b0);
      if (req_ready) acc++;
    end
    repeat (8) idle(1'b0);
    tests += 3;
    if (acc != 8) begin fails++; $display("FAIL bp_accepted got=%0d exp=8", acc); end
    if (req_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_full got=%b exp=0", req_ready); end
    if (busy !== 1'b1) begin fails++; $display("FAIL bp_busy got=%b exp=1", busy); end
    for (int i = 0; i < 20; i++) begin
      idle(1'b1);
      if (res_valid) begin
        tests += 2;
        if (res_tag !== TAG_W'(got)) begin fails++; $display("FAIL bp_tag got=%0d exp=%0d", res_tag, got); end
        if (res_data !== e_data) begin fails++; $display("FAIL bp_data got=%h exp=%h", res_data, e_data); end
        got++;
      end
    end
    tests++;
    if (got != 8) begin fails++; $display("FAIL bp_popped got=%0d exp=8", got); end
  endtask

  task automatic test_flush();
    int seen;
    seen = 0;
    for (int i = 0; i < 3; i++) tick(1'b1, 2'd0, 32'd2, 32'(i), TAG_W'(10 + i), 1'b1, 1'b0);
    idle(1'b1);
    tick(1'b1, 2'd0, 32'd5, 32'd6, 5'd13, 1'b1, 1'b1);
    tests++;
    if (req_ready !== 1'b0) begin fails++; $display("FAIL flush_ready got=%b exp=0", req_ready); end
    idle(1'b1);
    tests += 2;
    if (busy !== 1'b0) begin fails++; $display("FAIL flush_busy got=%b exp=0", busy); end
    if (res_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got=%b exp=0", res_valid); end
    for (int i = 0; i < 12; i++) begin
      idle(1'b1);
      if (res_valid) seen++;
    end
    tests++;
    if (seen != 0) begin fails++; $display("FAIL flush_ghost got=%0d exp=0", seen); end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 8; i++) tick(1'b1, 2'($urandom), pick_operand(), pick_operand(), TAG_W'(i), 1'b0, 1'b0);
    repeat (8) idle(1'b0);
    tests += 2;
    if (res_valid !== 1'b1) begin fails++; $display("FAIL full_valid got=%b exp=1", res_valid); end
    if (req_ready !== 1'b0) begin fails++; $display("FAIL full_ready got=%b exp=0", req_ready); end
    for (int i = 0; i < 24; i++) begin
      tick(1'b1, 2'($urandom), pick_operand(), pick_operand(), TAG_W'(16 + i), 1'b1, 1'b0);
      tests += 3;
      if (req_ready !== e_ready) begin fails++; $display("FAIL fp_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_ready); end
      if (res_valid !== e_valid) begin fails++; $display("FAIL fp_valid cyc=%0d got=%b exp=%b", cyc, res_valid, e_valid); end
      if (e_valid && {res_tag, res_data} !== {e_tag, e_data}) begin
        fails++; $display("FAIL fp_result cyc=%0d got=%h/%h exp=%h/%h", cyc, res_tag, res_data, e_tag, e_data);
      end
    end
  endtask

  task automatic test_random();
    logic v, rr, fl;
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 49) == 0);
      tick(v, 2'($urandom), pick_operand(), pick_operand(), TAG_W'($urandom), rr, fl);
      tests += 4;
      if (req_ready !== e_ready) begin fails++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_ready); end
      if (res_valid !== e_valid) begin fails++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, res_valid, e_valid); end
      if (busy !== e_busy) begin fails++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy); end
      if (e_valid && {res_tag, res_data} !== {e_tag, e_data}) begin
        fails++; $display("FAIL rnd_result cyc=%0d got=%h/%h exp=%h/%h", cyc, res_tag, res_data, e_tag, e_data);
      end
    end
  endtask

  task automatic test_reset_mid();
    int first;
    first = -1;
    for (int i = 0; i < 4; i++) tick(1'b1, 2'd1, pick_operand(), pick_operand(), TAG_W'(20 + i), 1'b0, 1'b0);
    idle(1'b0);
`ifdef MUL_PERF_CNT_EN
    tests += 2;
    if (perf_issued !== pf_iss) begin fails++; $display("FAIL perf_issued got=%0d exp=%0d", perf_issued, pf_iss); end
    if (perf_stall !== pf_stall) begin fails++; $display("FAIL perf_stall got=%0d exp=%0d", perf_stall, pf_stall); end
`endif
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    tests += 4;
    if (res_valid !== 1'b0) begin fails++; $display("FAIL rmid_valid got=%b exp=0", res_valid); end
    if ({res_tag, res_data} !== '0) begin fails++; $display("FAIL rmid_out got=%h/%h exp=0/0", res_tag, res_data); end
    if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    if (req_ready !== 1'b1) begin fails++; $display("FAIL rmid_ready got=%b exp=1", req_ready); end
    mq.delete();
    pf_iss = 0;
    pf_stall = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1, 2'd0, 32'd3, 32'd5, 5'd9, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      idle(1'b1);
      if (res_valid && first < 0) begin
        first = i;
        tests += 1;
        if ({res_tag, res_data} !== {5'd9, 32'd15}) begin
          fails++; $display("FAIL rmid_result got=%h/%h exp=09/0000000f", res_tag, res_data);
        end
      end
    end
    tests++;
    if (first != 6) begin fails++; $display("FAIL rmid_latency got=%0d exp=6", first); end
`ifdef MUL_PERF_CNT_EN
    tests += 2;
    if (perf_issued !== 32'd1) begin fails++; $display("FAIL perf_issued_post got=%0d exp=1", perf_issued); end
    if (perf_stall !== 32'd0) begin fails++; $display("FAIL perf_stall_post got=%0d exp=0", perf_stall); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    drain();
    test_ops();
    drain();
    test_back_pressure();
    drain();
    test_flush();
    drain();
    test_full_pop();
    drain();
    test_random();
    drain();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
